hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32 core; the stall/flush counterpart of the forwarding logic.
- Detects hazards that forwarding cannot resolve: load-use, branch operands still in flight, multi-cycle MDU ops, and data-memory wait states.
- Drives per-stage register enables and bubble/flush controls.
- Keeps an MDU busy FSM with watchdog and a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls and flushes the 5-stage RV32 pipeline for hazards
// that forwarding cannot cover, and tracks MDU busy time and total stall cycles.
module hazard_ctrl #(
   parameter int CNT_W   = 32,
   parameter int MDU_MAX = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       AA,
   input  logic [4:0]       BA,
   input  logic             useA,
   input  logic             useB,
   input  logic             BR,
   input  logic             br_taken,
   input  logic             ID_EX_RW,
   input  logic             ID_EX_MR,
   input  logic [4:0]       ID_EX_DA,
   input  logic             EX_MEM_MR,
   input  logic [4:0]       EX_MEM_DA,
   input  logic             mdu_start,
   input  logic             mdu_done,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic [1:0]       state,
   output logic             mdu_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MDU_BUSY = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;

   localparam int             MC_W    = $clog2(MDU_MAX + 1);
   localparam logic [MC_W-1:0] MDU_LIM = MC_W'(MDU_MAX);

   logic [1:0]       state_q, state_d;
   logic             done_lat_q, done_lat_d;
   logic [MC_W-1:0]  mdu_cnt_q, mdu_cnt_d;
   logic             mdu_timeout_q, mdu_timeout_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic hitA, hitB, matchEx, matchMem;
   logic lu, bex, bld, idstall, memw, mdub;

   // x0 is hard-wired zero, so a destination of x0 never creates a dependency
   always_comb begin
      hitA     = useA & (AA != 5'd0);
      hitB     = useB & (BA != 5'd0);
      matchEx  = (hitA & (ID_EX_DA == AA)) | (hitB & (ID_EX_DA == BA));
      matchMem = (hitA & (EX_MEM_DA == AA)) | (hitB & (EX_MEM_DA == BA));
      lu       = ID_EX_MR & matchEx;
      bex      = BR & ID_EX_RW & matchEx;
      bld      = BR & EX_MEM_MR & matchMem;
      idstall  = lu | bex | bld;
      memw     = mem_req & ~mem_ready;
      mdub     = ((state_q == MDU_BUSY) | mdu_start) & ~(mdu_done | done_lat_q);
   end

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      if (!rst) begin
         if (memw) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
         end else if (mdub) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
         end else if (idstall) begin
            // branch operands are stale here, so a taken resolution is not trusted
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end else if (br_taken) begin
            if_id_flush = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (memw)                        state_d = MEM_WAIT;
            else if (mdu_start && !mdu_done) state_d = MDU_BUSY;
         end
         MEM_WAIT: begin
            if (!memw) state_d = mdub ? MDU_BUSY : RUN;
         end
         MDU_BUSY: begin
            if (memw)                        state_d = MEM_WAIT;
            else if (mdu_done || done_lat_q) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // a done pulse seen during a memory wait is held until the wait releases
   always_comb begin
      done_lat_d    = memw ? (done_lat_q | mdu_done) : 1'b0;
      mdu_cnt_d     = '0;
      mdu_timeout_d = mdu_timeout_q;
      if ((state_q == MDU_BUSY) && (state_d == MDU_BUSY)) begin
         mdu_cnt_d     = (mdu_cnt_q == MDU_LIM) ? mdu_cnt_q : mdu_cnt_q + MC_W'(1);
         mdu_timeout_d = mdu_timeout_q | (mdu_cnt_d == MDU_LIM);
      end
      stall_count_d = stall_count_q;
      if (!pc_en && (stall_count_q != {CNT_W{1'b1}}))
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         done_lat_q    <= 1'b0;
         mdu_cnt_q     <= '0;
         mdu_timeout_q <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         done_lat_q    <= done_lat_d;
         mdu_cnt_q     <= mdu_cnt_d;
         mdu_timeout_q <= mdu_timeout_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign state       = state_q;
   assign mdu_timeout = mdu_timeout_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of single-cycle vectors plus
// multi-cycle sequences, all checked through an expected-result queue.
module tb_hazard_ctrl;

   localparam logic [3:0] EN_ALL    = 4'b1111;
   localparam logic [3:0] EN_ID     = 4'b0011;
   localparam logic [3:0] EN_MDU    = 4'b0001;
   localparam logic [3:0] EN_MEM    = 4'b0000;
   localparam logic [3:0] FL_NONE   = 4'b0000;
   localparam logic [3:0] FL_IFID   = 4'b1000;
   localparam logic [3:0] FL_IDEX   = 4'b0100;
   localparam logic [3:0] FL_EXMEM  = 4'b0010;
   localparam logic [3:0] FL_MEMWB  = 4'b0001;

   typedef struct {
      int         tag;
      logic       rstIn;
      logic [4:0] aa, ba;
      logic       useA, useB, br, brTaken, idExRw, idExMr;
      logic [4:0] idExDa;
      logic       exMemMr;
      logic [4:0] exMemDa;
      logic       mduStart, mduDone, memReq, memReady;
      logic [3:0] expEn;
      logic [3:0] expFlush;
      logic [1:0] expState;
      logic       expTimeout;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  AA, BA, ID_EX_DA, EX_MEM_DA;
   logic        useA, useB, BR, br_taken, ID_EX_RW, ID_EX_MR, EX_MEM_MR;
   logic        mdu_start, mdu_done, mem_req, mem_ready;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic [1:0]  state;
   logic        mdu_timeout;
   logic [31:0] stall_count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] modelStall = 32'd0;
   vec_t        expQ[$];
   vec_t        tbl[18];

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(32), .MDU_MAX(64)) dut (
      .clk(clk), .rst(rst), .AA(AA), .BA(BA), .useA(useA), .useB(useB),
      .BR(BR), .br_taken(br_taken), .ID_EX_RW(ID_EX_RW), .ID_EX_MR(ID_EX_MR),
      .ID_EX_DA(ID_EX_DA), .EX_MEM_MR(EX_MEM_MR), .EX_MEM_DA(EX_MEM_DA),
      .mdu_start(mdu_start), .mdu_done(mdu_done), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
      .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
      .mem_wb_flush(mem_wb_flush), .state(state), .mdu_timeout(mdu_timeout),
      .stall_count(stall_count)
   );

   function automatic vec_t idle(input int tag);
      vec_t v;
      v.tag = tag;       v.rstIn = 1'b0;
      v.aa = 5'd0;       v.ba = 5'd0;
      v.useA = 1'b0;     v.useB = 1'b0;    v.br = 1'b0;      v.brTaken = 1'b0;
      v.idExRw = 1'b0;   v.idExMr = 1'b0;  v.idExDa = 5'd0;
      v.exMemMr = 1'b0;  v.exMemDa = 5'd0;
      v.mduStart = 1'b0; v.mduDone = 1'b0; v.memReq = 1'b0;  v.memReady = 1'b0;
      v.expEn = EN_ALL;  v.expFlush = FL_NONE;
      v.expState = 2'd0; v.expTimeout = 1'b0;
      return v;
   endfunction

   task automatic cmp(input int tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL vec %0d %s: got %0h expected %0h", tag, what, act, exp);
      end
   endtask

   task automatic checkOutput();
      vec_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      e = expQ.pop_front();
      cmp(e.tag, "enables", {28'd0, pc_en, if_id_en, id_ex_en, ex_mem_en}, {28'd0, e.expEn});
      cmp(e.tag, "flushes", {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
          {28'd0, e.expFlush});
      cmp(e.tag, "state", {30'd0, state}, {30'd0, e.expState});
      cmp(e.tag, "mdu_timeout", {31'd0, mdu_timeout}, {31'd0, e.expTimeout});
      cmp(e.tag, "stall_count", stall_count, modelStall);
      if (e.rstIn)
         modelStall = 32'd0;
      else if (!e.expEn[3])
         modelStall = modelStall + 32'd1;
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      rst = v.rstIn;
      AA = v.aa;  BA = v.ba;  useA = v.useA;  useB = v.useB;
      BR = v.br;  br_taken = v.brTaken;
      ID_EX_RW = v.idExRw;  ID_EX_MR = v.idExMr;  ID_EX_DA = v.idExDa;
      EX_MEM_MR = v.exMemMr;  EX_MEM_DA = v.exMemDa;
      mdu_start = v.mduStart;  mdu_done = v.mduDone;
      mem_req = v.memReq;  mem_ready = v.memReady;
      expQ.push_back(v);
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      vec_t v;
      rst = 1'b1;
      AA = '0; BA = '0; useA = 0; useB = 0; BR = 0; br_taken = 0;
      ID_EX_RW = 0; ID_EX_MR = 0; ID_EX_DA = '0; EX_MEM_MR = 0; EX_MEM_DA = '0;
      mdu_start = 0; mdu_done = 0; mem_req = 0; mem_ready = 0;

      // single-cycle hazard decode, all taken from the RUN state
      foreach (tbl[i]) tbl[i] = idle(i);
      tbl[0].rstIn = 1'b1;
      tbl[2].idExMr = 1; tbl[2].idExDa = 5; tbl[2].useA = 1; tbl[2].aa = 5;
      tbl[2].expEn = EN_ID; tbl[2].expFlush = FL_IDEX;
      tbl[4].idExMr = 1; tbl[4].idExDa = 9; tbl[4].useB = 1; tbl[4].ba = 9;
      tbl[4].expEn = EN_ID; tbl[4].expFlush = FL_IDEX;
      tbl[5].idExMr = 1; tbl[5].idExDa = 0; tbl[5].useA = 1; tbl[5].aa = 0;
      tbl[6].idExMr = 1; tbl[6].idExDa = 5; tbl[6].useA = 0; tbl[6].aa = 5;
      tbl[7].idExRw = 1; tbl[7].idExDa = 6; tbl[7].useA = 1; tbl[7].aa = 6;
      tbl[8].br = 1; tbl[8].idExRw = 1; tbl[8].idExDa = 3; tbl[8].useB = 1; tbl[8].ba = 3;
      tbl[8].expEn = EN_ID; tbl[8].expFlush = FL_IDEX;
      tbl[9].br = 1; tbl[9].exMemMr = 1; tbl[9].exMemDa = 4; tbl[9].useA = 1; tbl[9].aa = 4;
      tbl[9].expEn = EN_ID; tbl[9].expFlush = FL_IDEX;
      tbl[10].exMemMr = 1; tbl[10].exMemDa = 4; tbl[10].useA = 1; tbl[10].aa = 4;
      tbl[11].brTaken = 1; tbl[11].expFlush = FL_IFID;
      tbl[12].brTaken = 1; tbl[12].idExMr = 1; tbl[12].idExDa = 8; tbl[12].useA = 1;
      tbl[12].aa = 8; tbl[12].expEn = EN_ID; tbl[12].expFlush = FL_IDEX;
      tbl[13].mduStart = 1; tbl[13].mduDone = 1;
      tbl[15].memReq = 1; tbl[15].memReady = 1;
      tbl[16].br = 1; tbl[16].idExRw = 1; tbl[16].idExDa = 3; tbl[16].useB = 1; tbl[16].ba = 4;
      tbl[17].br = 1; tbl[17].idExRw = 1; tbl[17].idExDa = 0; tbl[17].useA = 1; tbl[17].aa = 0;
      for (int i = 0; i < 18; i++) applyStimulus(tbl[i]);

      // load x7 feeding a branch: stall on the EX match, then on the MEM match
      for (int i = 0; i < 3; i++) begin
         v = idle(100 + i);
         v.br = 1; v.useA = 1; v.aa = 7; v.brTaken = 1;
         if (i == 0) begin v.idExMr = 1; v.idExRw = 1; v.idExDa = 7; end
         if (i == 1) begin v.exMemMr = 1; v.exMemDa = 7; end
         v.expEn = (i < 2) ? EN_ID : EN_ALL;
         v.expFlush = (i < 2) ? FL_IDEX : FL_IFID;
         applyStimulus(v);
      end

      // MDU op completing five cycles after it enters EX
      for (int i = 0; i < 7; i++) begin
         v = idle(200 + i);
         v.mduStart = (i < 6);
         v.mduDone = (i == 5);
         v.expState = (i >= 1 && i <= 5) ? 2'd1 : 2'd0;
         if (i < 5) begin v.expEn = EN_MDU; v.expFlush = FL_EXMEM; end
         applyStimulus(v);
      end

      // MDU done arrives in the middle of a memory wait and must not be lost
      for (int i = 0; i < 7; i++) begin
         v = idle(300 + i);
         v.mduStart = (i < 6);
         v.memReq = (i >= 2 && i <= 5);
         v.memReady = (i == 5);
         v.mduDone = (i == 3);
         v.expState = (i == 0 || i == 6) ? 2'd0 : (i <= 2) ? 2'd1 : 2'd2;
         if (i <= 1) begin v.expEn = EN_MDU; v.expFlush = FL_EXMEM; end
         if (i >= 2 && i <= 4) begin v.expEn = EN_MEM; v.expFlush = FL_MEMWB; end
         applyStimulus(v);
      end

      // MDU that never finishes trips the watchdog, then reset mid-stall
      for (int i = 0; i < 67; i++) begin
         v = idle(400 + i);
         v.mduStart = 1;
         v.expEn = EN_MDU; v.expFlush = FL_EXMEM;
         v.expState = (i == 0) ? 2'd0 : 2'd1;
         v.expTimeout = (i >= 65);
         applyStimulus(v);
      end
      v = idle(500);
      v.rstIn = 1; v.mduStart = 1; v.expState = 2'd1; v.expTimeout = 1;
      applyStimulus(v);
      applyStimulus(idle(501));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
